resp_fifo_sched: RTL and testbench

Response scheduler between the result producers (ALU, register file read port) and the TX async FIFO write port, all in the REF_CLK domain. It buffers one pending ALU result and one pending register read. Requests are arbitrated round-robin. The 16-bit ALU result is serialized into two bytes, and writes are throttled by FIFO_FULL so no response byte is lost or duplicated.

---
 rtl/resp_fifo_sched.sv | 136 +++++++++++++
 tb/tb_resp_fifo_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/resp_fifo_sched.sv
// rtl/resp_fifo_sched.sv - response scheduler: ALU/RegFile result slots arbitrated into the TX FIFO write port
module resp_fifo_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_Valid,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] FIFO_WrData,
    output logic                  FIFO_WrInc,
    output logic                  busy,
    output logic                  drop_err
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_REG    = 2'd1,
        SEND_ALU_B0 = 2'd2,
        SEND_ALU_B1 = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ALU_WIDTH-1:0]    alu_data_q, alu_data_d;
    logic                    alu_pend_q, alu_pend_d;
    logic [DATA_WIDTH-1:0]   reg_data_q, reg_data_d;
    logic                    reg_pend_q, reg_pend_d;
    logic                    last_grant_alu_q, last_grant_alu_d;
    logic                    drop_err_q, drop_err_d;

    logic                    reg_free;
    logic                    alu_free;
    logic [DATA_WIDTH-1:0]   alu_lo;
    logic [DATA_WIDTH-1:0]   alu_hi;

    assign alu_lo   = alu_data_q[DATA_WIDTH-1:0];
    assign alu_hi   = alu_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign reg_free = (state_q == SEND_REG)    && !FIFO_FULL;
    assign alu_free = (state_q == SEND_ALU_B1) && !FIFO_FULL;

    always_comb begin
        state_d          = state_q;
        last_grant_alu_d = last_grant_alu_q;
        case (state_q)
            IDLE: begin
                // last_grant only moves when a genuine tie is arbitrated
                if (reg_pend_q && alu_pend_q) begin
                    if (last_grant_alu_q) begin
                        state_d          = SEND_REG;
                        last_grant_alu_d = 1'b0;
                    end else begin
                        state_d          = SEND_ALU_B0;
                        last_grant_alu_d = 1'b1;
                    end
                end else if (reg_pend_q) begin
                    state_d = SEND_REG;
                end else if (alu_pend_q) begin
                    state_d = SEND_ALU_B0;
                end
            end
            SEND_REG:    if (!FIFO_FULL) state_d = IDLE;
            SEND_ALU_B0: if (!FIFO_FULL) state_d = SEND_ALU_B1;
            SEND_ALU_B1: if (!FIFO_FULL) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // A slot accepts a new strobe when empty or when its last byte leaves this cycle
    always_comb begin
        reg_data_d = reg_data_q;
        reg_pend_d = reg_pend_q;
        alu_data_d = alu_data_q;
        alu_pend_d = alu_pend_q;
        drop_err_d = 1'b0;

        if (reg_free) reg_pend_d = 1'b0;
        if (alu_free) alu_pend_d = 1'b0;

        if (RdData_Valid) begin
            if (!reg_pend_q || reg_free) begin
                reg_data_d = RdData;
                reg_pend_d = 1'b1;
            end else begin
                drop_err_d = 1'b1;
            end
        end

        if (ALU_OUT_Valid) begin
            if (!alu_pend_q || alu_free) begin
                alu_data_d = ALU_OUT;
                alu_pend_d = 1'b1;
            end else begin
                drop_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        FIFO_WrData = '0;
        case (state_q)
            SEND_REG:    FIFO_WrData = reg_data_q;
            SEND_ALU_B0: FIFO_WrData = LSB_FIRST ? alu_lo : alu_hi;
            SEND_ALU_B1: FIFO_WrData = LSB_FIRST ? alu_hi : alu_lo;
            default:     FIFO_WrData = '0;
        endcase
    end

    assign FIFO_WrInc = (state_q != IDLE) && !FIFO_FULL;
    assign busy       = (state_q != IDLE) || alu_pend_q || reg_pend_q;
    assign drop_err   = drop_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= IDLE;
            alu_data_q       <= '0;
            alu_pend_q       <= 1'b0;
            reg_data_q       <= '0;
            reg_pend_q       <= 1'b0;
            last_grant_alu_q <= 1'b1;
            drop_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            alu_data_q       <= alu_data_d;
            alu_pend_q       <= alu_pend_d;
            reg_data_q       <= reg_data_d;
            reg_pend_q       <= reg_pend_d;
            last_grant_alu_q <= last_grant_alu_d;
            drop_err_q       <= drop_err_d;
        end
    end

endmodule

// File: tb/tb_resp_fifo_sched.sv
// tb/tb_resp_fifo_sched.sv - per-cycle vector table plus hand sequences for resp_fifo_sched
module tb_resp_fifo_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_Valid;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic        FIFO_FULL;
    logic [7:0]  FIFO_WrData;
    logic        FIFO_WrInc;
    logic        busy;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    resp_fifo_sched #(.DATA_WIDTH(8), .ALU_WIDTH(16), .LSB_FIRST(1'b1)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ALU_OUT      (ALU_OUT),
        .ALU_OUT_Valid(ALU_OUT_Valid),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .FIFO_FULL    (FIFO_FULL),
        .FIFO_WrData  (FIFO_WrData),
        .FIFO_WrInc   (FIFO_WrInc),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [7:0]  rd;
        logic        av;
        logic [15:0] ad;
        logic        full;
        logic        e_wi;
        logic [7:0]  e_wd;
        logic        e_busy;
        logic        e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic rv, logic [7:0] rd, logic av, logic [15:0] ad,
                               logic full, logic e_wi, logic [7:0] e_wd, logic e_busy, logic e_drop);
        vec_t r;
        r.rst = rst; r.rv = rv; r.rd = rd; r.av = av; r.ad = ad; r.full = full;
        r.e_wi = e_wi; r.e_wd = e_wd; r.e_busy = e_busy; r.e_drop = e_drop;
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        RdData_Valid  = 1'b0;
        RdData        = 8'h00;
        ALU_OUT_Valid = 1'b0;
        ALU_OUT       = 16'h0000;
        FIFO_FULL     = 1'b0;
    endtask

    logic [7:0] got[$];

    initial begin
        RST = 1'b1;
        drive_idle();

        // reg A5 alone
        vecs.push_back(v(0,1,8'hA5,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'hA5,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        // ALU 1234 alone, low byte first
        vecs.push_back(v(1,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,1,16'h1234,0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h34,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h12,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        // ties: first to REG, second to ALU
        vecs.push_back(v(1,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,1,8'h5A,1,16'hBEEF,0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h5A,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'hEF,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'hBE,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,1,8'h11,1,16'h2233,0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h33,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h22,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h11,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        // ALU 1234 stalled on B1 by FULL in cycles 3..7, reg 77 arrives in cycle 4
        vecs.push_back(v(1,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,1,16'h1234,0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h34,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   1, 0,8'h12,1,0));
        vecs.push_back(v(0,1,8'h77,0,16'h0,   1, 0,8'h12,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   1, 0,8'h12,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   1, 0,8'h12,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   1, 0,8'h12,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h12,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h77,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        // second ALU strobe into a pending slot is dropped
        vecs.push_back(v(1,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,1,16'h1111,0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,1,16'h2222,0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h11,1,1));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h11,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        // reg strobe in the freeing cycle is captured, not dropped
        vecs.push_back(v(1,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,1,8'h01,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,1,8'h02,0,16'h0,   0, 1,8'h01,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'h02,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        // reset during a stalled B1 aborts the transfer
        vecs.push_back(v(1,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,1,16'hABCD,0, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 1,8'hCD,1,0));
        vecs.push_back(v(1,0,8'h00,0,16'h0,   1, 0,8'hAB,1,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   1, 0,8'h00,0,0));
        vecs.push_back(v(0,0,8'h00,0,16'h0,   0, 0,8'h00,0,0));

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset_wrinc", {15'd0, FIFO_WrInc}, 16'd0);
        chk("reset_wrdata", {8'd0, FIFO_WrData}, 16'd0);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_drop", {15'd0, drop_err}, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RST           = vecs[i].rst;
            RdData_Valid  = vecs[i].rv;
            RdData        = vecs[i].rd;
            ALU_OUT_Valid = vecs[i].av;
            ALU_OUT       = vecs[i].ad;
            FIFO_FULL     = vecs[i].full;
            #1;
            chk($sformatf("v%0d_wrinc", i), {15'd0, FIFO_WrInc}, {15'd0, vecs[i].e_wi});
            chk($sformatf("v%0d_wrdata", i), {8'd0, FIFO_WrData}, {8'd0, vecs[i].e_wd});
            chk($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_drop", i), {15'd0, drop_err}, {15'd0, vecs[i].e_drop});
        end

        // FULL toggling every cycle: each ALU byte lands exactly once, in order
        @(negedge CLK);
        RST = 1'b1;
        drive_idle();
        @(negedge CLK);
        RST           = 1'b0;
        ALU_OUT_Valid = 1'b1;
        ALU_OUT       = 16'h5566;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            ALU_OUT_Valid = 1'b0;
            FIFO_FULL     = c[0];
            #1;
            if (FIFO_WrInc) got.push_back(FIFO_WrData);
        end
        FIFO_FULL = 1'b0;
        chk("toggle_count", 16'(got.size()), 16'd2);
        if (got.size() == 2) begin
            chk("toggle_b0", {8'd0, got[0]}, 16'h0066);
            chk("toggle_b1", {8'd0, got[1]}, 16'h0055);
        end
        chk("toggle_busy_end", {15'd0, busy}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
